// File: rtl/hazard_fwd_if.sv
// Issue-side bundle between decode and the hazard/forwarding unit.
// The master is the decode stage; the slave is the hazard unit.
interface hazard_fwd_if #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned FWD_DEPTH = 3,
    parameter int unsigned CNT_W     = 16
);
    localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

    logic             issue_valid;
    logic [REG_W-1:0] issue_rs;
    logic [REG_W-1:0] issue_rt;
    logic             issue_use_rs;
    logic             issue_use_rt;
    logic             issue_wr_en;
    logic [REG_W-1:0] issue_wr_reg;
    logic             issue_is_load;
    logic             branch_taken;
    logic             ext_stall;
    logic [SEL_W-1:0] fwd_sel_a;
    logic [SEL_W-1:0] fwd_sel_b;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt, issue_wr_en,
        output issue_wr_reg, issue_is_load, branch_taken, ext_stall,
        input  fwd_sel_a, fwd_sel_b, stall, flush, stall_count
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt, issue_wr_en,
        input  issue_wr_reg, issue_is_load, branch_taken, ext_stall,
        output fwd_sel_a, fwd_sel_b, stall, flush, stall_count
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Forwarding and interlock unit: scoreboard of the last FWD_DEPTH issued writers,
// per-operand forwarding selects, load-use stalls, branch flushes and a stall counter.
module hazard_fwd_unit #(
    parameter int unsigned REG_W     = 5,
    parameter int unsigned FWD_DEPTH = 3,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned CNT_W     = 16
) (
    input logic        clk,
    input logic        rst_n,
    hazard_fwd_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(FWD_DEPTH + 1);

    // Entry k holds the instruction issued k advancing cycles ago.
    logic [FWD_DEPTH:1]            ent_v_q;
    logic [FWD_DEPTH:1][REG_W-1:0] ent_reg_q;
    logic [FWD_DEPTH:1]            ent_load_q;
    logic [CNT_W-1:0]              cnt_q;

    logic [SEL_W-1:0] sel_a, sel_b;
    logic             haz_a, haz_b;
    logic             stall_raw, flush_raw;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
            if (ent_v_q[k] && ent_reg_q[k] == bus.issue_rs && bus.issue_rs != '0) begin
                sel_a = SEL_W'(k);
                haz_a = ent_load_q[k] && (k <= int'(LOAD_LAT));
            end
            if (ent_v_q[k] && ent_reg_q[k] == bus.issue_rt && bus.issue_rt != '0) begin
                sel_b = SEL_W'(k);
                haz_b = ent_load_q[k] && (k <= int'(LOAD_LAT));
            end
        end
        if (!bus.issue_use_rs) begin
            sel_a = '0;
            haz_a = 1'b0;
        end
        if (!bus.issue_use_rt) begin
            sel_b = '0;
            haz_b = 1'b0;
        end
    end

    assign stall_raw = bus.issue_valid & (haz_a | haz_b) & ~bus.branch_taken & ~bus.ext_stall;
    assign flush_raw = bus.branch_taken & ~bus.ext_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v_q    <= '0;
            ent_reg_q  <= '0;
            ent_load_q <= '0;
        end else if (!bus.ext_stall) begin
            for (int k = int'(FWD_DEPTH); k >= 2; k--) begin
                ent_v_q[k]    <= ent_v_q[k-1];
                ent_reg_q[k]  <= ent_reg_q[k-1];
                ent_load_q[k] <= ent_load_q[k-1];
            end
            // A stalled or flushed issue enters as a bubble.
            ent_v_q[1]    <= bus.issue_valid & bus.issue_wr_en & ~stall_raw & ~flush_raw;
            ent_reg_q[1]  <= bus.issue_wr_reg;
            ent_load_q[1] <= bus.issue_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall_raw && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.fwd_sel_a   = rst_n ? sel_a : '0;
    assign bus.fwd_sel_b   = rst_n ? sel_b : '0;
    assign bus.stall       = rst_n & stall_raw;
    assign bus.flush       = rst_n & flush_raw;
    assign bus.stall_count = cnt_q;
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised forwarding and interlock unit for the MIPS150 datapath.
- Replaces the single-previous-instruction forwarding compare with a scoreboard of the last FWD_DEPTH issued writers.
- Generates per-operand forwarding selects, load-use stalls of configurable latency and branch-flush bubbles, and counts stall cycles.
- Sits between decode (issue stage) and the ALU operand muxes.

Parameters:
- REG_W, 5, register-index width.
- FWD_DEPTH, 3, number of in-flight stages tracked; legal range 2..7.
- LOAD_LAT, 1, extra cycles after issue before load data is forwardable; must be < FWD_DEPTH.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode stage holds a real instruction
- issue_rs  in  REG_W  source A index
- issue_rt  in  REG_W  source B index
- issue_use_rs  in  1  instruction reads rs
- issue_use_rt  in  1  instruction reads rt
- issue_wr_en  in  1  instruction writes a register
- issue_wr_reg  in  REG_W  destination index (rd, rt or 31 already resolved)
- issue_is_load  in  1  instruction is LB/LH/LW/LBU/LHU
- branch_taken  in  1  branch/jump resolved taken this cycle
- ext_stall  in  1  freeze from memory-mapped I/O (UART not ready)
- fwd_sel_a  out  $clog2(FWD_DEPTH+1)  0 = register file, k = stage k result
- fwd_sel_b  out  $clog2(FWD_DEPTH+1)  same encoding, operand B
- stall  out  1  hold PC and decode register
- flush  out  1  squash decode-stage instruction
- stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Scoreboard: entries 1..FWD_DEPTH, each {v, wr_reg, is_load}. Entry k is the instruction issued k advancing cycles ago.
- Reset (rst_n=0, asynchronous):
  - all entry v=0.
  - stall_count=0.
  - fwd_sel_a=fwd_sel_b=0, stall=0, flush=0; these outputs are combinational and are forced low while in reset.
- Match rule:
  - Entry k matches source s if v=1 and wr_reg==s and s!=0.
  - The youngest (smallest k) match wins.
  - fwd_sel = k of the winner; 0 if no match or the operand is unused.
- Load-use rule: if the winning match for any used operand has is_load=1 and k<=LOAD_LAT, then hazard=1.
- stall = issue_valid & hazard & ~branch_taken & ~ext_stall.
- flush = branch_taken & ~ext_stall.
- While hazard=1, fwd_sel_a/b are still driven but are don't-care.
- Advance (posedge, when ext_stall=0):
  - entry k+1 <= entry k; the oldest entry is dropped.
  - entry 1 <= {issue_valid & issue_wr_en & ~stall & ~flush, issue_wr_reg, issue_is_load}.
  - Net effect: a stall or flush inserts a bubble (v=0) at entry 1.
- ext_stall=1:
  - No shift and no counter change.
  - stall and flush forced to 0; the external freeze already holds the pipe.
  - fwd_sel keeps tracking the current inputs.
- Stall duration: a load at entry 1 with LOAD_LAT=L blocks its dependent for exactly L cycles as it ages to entry L+1. This needs no separate counter.
- Simultaneous branch_taken and hazard: flush wins, stall=0, bubble inserted, no stall counted.
- Writes to register 0 never match.
- A duplicate destination in several entries forwards from the youngest.
- stall_count increments on each cycle with stall=1 and saturates at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stall clears all state immediately. The first cycle after release has no hazards.
- Implementation target is 150-250 lines of RTL.

Test Plan:
- ALU chain: issue ADDIU wr $5, then ADDU reading rs=$5 -> next cycle fwd_sel_a=1, stall=0; one further unrelated instruction later -> fwd_sel_a=2.
- Load-use (LOAD_LAT=1): LW wr $8, then ADD reading rt=$8 -> stall=1 for exactly 1 cycle, then fwd_sel_b=2; stall_count=1.
- LOAD_LAT=2 build: same sequence -> stall=1 for 2 cycles, then fwd_sel_b=3; stall_count=2.
- $0 and youngest-wins: ADDIU wr $0 then use $0 -> fwd_sel=0. Two writers to $9 issued back-to-back, then use $9 -> fwd_sel=1, not 2.
- Flush vs stall: load-use hazard with branch_taken=1 in the same cycle -> flush=1, stall=0, entry 1 invalid, stall_count unchanged. With ext_stall=1 held for 3 cycles -> scoreboard frozen and selects unchanged.
- Reset and saturation:
  - rst_n pulsed low mid-stall -> stall=0 and all selects 0 immediately, no hazards after release.
  - CNT_W=2 build with 5 stall cycles -> stall_count holds at 3.
